bus_arbiter: RTL and testbench

Two-master bus arbiter. It sits directly downstream of the master control paths: it consumes their `busreq_1`/`busreq_2` requests and returns `grant_1`/`grant_2`. At most one master owns the shared source/destination bus at any time. The arbiter also provides one guaranteed dead cycle between owners, optional round-robin fairness, and a tenure limit that preempts a master hogging the bus.

---
 rtl/bus_pkg.sv | 32 +++
 rtl/tenure_counter.sv | 26 ++
 rtl/bus_arbiter.sv | 109 ++++++++++
 tb/tb_bus_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared bus ownership types for the arbiter and the master control paths.
// State and owner codes share one encoding, so a grant state maps directly to an owner code.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT1 = 2'b01,
    GNT2 = 2'b10
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_M1   = 2'b01,
    OWN_M2   = 2'b10
  } owner_e;

  localparam int PRIO_FIXED = 0;
  localparam int PRIO_RR    = 1;

  function automatic owner_e other_master(input owner_e o);
    return (o == OWN_M1) ? OWN_M2 : OWN_M1;
  endfunction

  function automatic owner_e state_owner(input arb_state_e s);
    case (s)
      GNT1:    return OWN_M1;
      GNT2:    return OWN_M2;
      default: return OWN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/tenure_counter.sv
// Saturating count of consecutive granted cycles; hit flags the last cycle
// the current owner may keep the bus while the other master waits.
module tenure_counter #(
  parameter int MAX_TENURE = 16,
  parameter int CNT_W      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'((MAX_TENURE == 0) ? 0 : MAX_TENURE - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     cnt <= '0;
    else if (clr)                cnt <= '0;
    else if (inc && cnt != '1)   cnt <= cnt + 1'b1;
  end

  assign hit = (MAX_TENURE != 0) && (cnt == LIMIT);

endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter: IDLE dead cycle between owners, fixed or round-robin
// tie-break, and tenure-limit preemption when the other master is waiting.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int PRIORITY_MODE = PRIO_RR,
  parameter int MAX_TENURE    = 16,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       busreq_1,
  input  logic       busreq_2,
  output logic       grant_1,
  output logic       grant_2,
  output logic       bus_busy,
  output logic [1:0] owner,
  output logic       preempt
);

  arb_state_e state_q, state_d;
  owner_e     last_q, last_d, tie_winner;
  logic       force_q, force_d;
  logic       preempt_d;
  logic       hit;

  // The counter is held clear through IDLE, which makes it zero on every grant entry.
  tenure_counter #(
    .MAX_TENURE (MAX_TENURE),
    .CNT_W      (CNT_W)
  ) u_tenure (
    .clk (clk),
    .rst (rst),
    .clr (state_q == IDLE),
    .inc (state_q != IDLE),
    .hit (hit)
  );

  // After a preempt the waiting master wins even in fixed-priority mode.
  assign tie_winner = (force_q || PRIORITY_MODE == PRIO_RR) ? other_master(last_q) : OWN_M1;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    force_d   = force_q;
    preempt_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (busreq_1 && busreq_2) state_d = (tie_winner == OWN_M1) ? GNT1 : GNT2;
        else if (busreq_1)        state_d = GNT1;
        else if (busreq_2)        state_d = GNT2;
        if (state_d != IDLE)      force_d = 1'b0;
      end
      GNT1: begin
        if (!busreq_1) begin
          state_d = IDLE;
          last_d  = OWN_M1;
        end else if (hit && busreq_2) begin
          state_d   = IDLE;
          last_d    = OWN_M1;
          force_d   = 1'b1;
          preempt_d = 1'b1;
        end
      end
      GNT2: begin
        if (!busreq_2) begin
          state_d = IDLE;
          last_d  = OWN_M2;
        end else if (hit && busreq_1) begin
          state_d   = IDLE;
          last_d    = OWN_M2;
          force_d   = 1'b1;
          preempt_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= OWN_M2;
      force_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      force_q <= force_d;
    end
  end

  // Outputs come from the next state so grants, owner and busy flip on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_1  <= 1'b0;
      grant_2  <= 1'b0;
      bus_busy <= 1'b0;
      owner    <= OWN_NONE;
      preempt  <= 1'b0;
    end else begin
      grant_1  <= (state_d == GNT1);
      grant_2  <= (state_d == GNT2);
      bus_busy <= (state_d != IDLE);
      owner    <= state_owner(state_d);
      preempt  <= preempt_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Four arbiter configurations driven by shared requests, each checked every
// cycle against a cycle-count reference model, plus directed scenarios.
module tb_bus_arbiter;

  localparam int N = 4;
  localparam int MODE [N] = '{1, 0, 1, 0};
  localparam int TEN  [N] = '{16, 16, 4, 0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req1 = 1'b0, req2 = 1'b0;
  logic [N-1:0] g1, g2, busy, pre;
  logic [1:0]   own [N];

  int n_chk = 0, n_err = 0;

  int m_own [N], m_ten [N], m_last [N], prev_own [N];
  bit m_force [N], m_pre [N];

  always #5 clk = ~clk;

  for (genvar i = 0; i < N; i++) begin : g_dut
    bus_arbiter #(.PRIORITY_MODE(MODE[i]), .MAX_TENURE(TEN[i]), .CNT_W(8)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .busreq_1 (req1),
      .busreq_2 (req2),
      .grant_1  (g1[i]),
      .grant_2  (g2[i]),
      .bus_busy (busy[i]),
      .owner    (own[i]),
      .preempt  (pre[i])
    );
  end

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_own[i] = 0; m_ten[i] = 0; m_last[i] = 2; m_force[i] = 0; m_pre[i] = 0; prev_own[i] = 0;
    end
  endfunction

  // Owner 1/2 or 0; m_ten counts cycles the current owner has held the bus.
  function automatic void model_step(input int i, input bit r1, input bit r2);
    int win;
    bit mine, other;
    if (m_own[i] == 0) begin
      m_pre[i] = 0;
      win = 0;
      if (r1 && r2) win = (m_force[i] || MODE[i] == 1) ? 3 - m_last[i] : 1;
      else if (r1)  win = 1;
      else if (r2)  win = 2;
      if (win != 0) begin
        m_own[i] = win; m_ten[i] = 1; m_force[i] = 0;
      end
    end else begin
      mine  = (m_own[i] == 1) ? r1 : r2;
      other = (m_own[i] == 1) ? r2 : r1;
      if (!mine) begin
        m_last[i] = m_own[i]; m_own[i] = 0;
      end else if (TEN[i] != 0 && other && m_ten[i] == TEN[i]) begin
        m_last[i] = m_own[i]; m_own[i] = 0; m_force[i] = 1; m_pre[i] = 1;
      end else begin
        m_ten[i]++;
      end
    end
  endfunction

  function automatic int act_pack(input int i);
    return (int'(g1[i]) << 5) | (int'(g2[i]) << 4) | (int'(busy[i]) << 3) | (int'(pre[i]) << 2) | int'(own[i]);
  endfunction

  function automatic int exp_pack(input int i);
    return (int'(m_own[i] == 1) << 5) | (int'(m_own[i] == 2) << 4) | (int'(m_own[i] != 0) << 3)
         | (int'(m_pre[i]) << 2) | m_own[i];
  endfunction

  task automatic cycle();
    @(posedge clk);
    for (int i = 0; i < N; i++) model_step(i, req1, req2);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("outputs[%0d]", i), act_pack(i), exp_pack(i));
      chk($sformatf("excl[%0d]", i), int'(g1[i] & g2[i]), 0);
      chk($sformatf("dead_time[%0d]", i),
          int'(prev_own[i] != 0 && own[i] != 0 && prev_own[i] != int'(own[i])), 0);
      prev_own[i] = int'(own[i]);
    end
  endtask

  // Asynchronous reset applied between edges; outputs must clear before any clock edge.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < N; i++) chk($sformatf("async_rst[%0d]", i), act_pack(i), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int own_seq [11];
    int rr_exp  [11] = '{1, 1, 1, 1, 0, 2, 2, 2, 2, 0, 1};
    int t4_exp  [7]  = '{1, 1, 1, 1, 0, 2, 2};
    int t4_seq  [7];
    int t4_pre4, t0_g1, t0_g2, t0_pre, fix_run, run, prev, found;
    bit fix_done;

    model_reset();
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < N; i++) chk($sformatf("reset_state[%0d]", i), act_pack(i), 0);
    rst = 1'b0;

    // Single request, grant latency and release.
    cycle();
    req1 = 1'b1;
    cycle();
    chk("p1_grant_1", int'(g1[0]), 1);
    chk("p1_owner", int'(own[0]), 1);
    repeat (3) cycle();
    req1 = 1'b0;
    cycle();
    chk("p1_release", int'(g1[0]), 0);
    cycle();

    // Round-robin alternation with 4-cycle transfers.
    do_reset();
    req1 = 1'b1; req2 = 1'b1;
    run = 0; prev = 0;
    for (int k = 0; k < 11; k++) begin
      cycle();
      own_seq[k] = int'(own[0]);
      run = (own_seq[k] != 0 && own_seq[k] == prev) ? run + 1 : (own_seq[k] != 0 ? 1 : 0);
      prev = own_seq[k];
      req1 = 1'b1; req2 = 1'b1;
      if (run == 4) begin
        if (own_seq[k] == 1) req1 = 1'b0; else req2 = 1'b0;
      end
    end
    for (int k = 0; k < 11; k++) chk($sformatf("rr_seq[%0d]", k), own_seq[k], rr_exp[k]);

    // Both held: fixed/16 tenure, round-robin/4 tenure, preemption disabled.
    do_reset();
    req1 = 1'b1; req2 = 1'b1;
    t0_g1 = 0; t0_g2 = 0; t0_pre = 0; fix_run = 0; fix_done = 0; t4_pre4 = 0;
    for (int k = 0; k < 301; k++) begin
      cycle();
      if (k < 7) t4_seq[k] = int'(own[2]);
      if (k == 4) t4_pre4 = int'(pre[2]);
      t0_g1  += int'(g1[3]);
      t0_g2  += int'(g2[3]);
      t0_pre += int'(pre[3]);
      if (!fix_done) begin
        if (g1[1]) fix_run++; else fix_done = 1;
      end
    end
    for (int k = 0; k < 7; k++) chk($sformatf("t4_seq[%0d]", k), t4_seq[k], t4_exp[k]);
    chk("t4_preempt_pulse", t4_pre4, 1);
    chk("fixed_tenure_run", fix_run, 16);
    chk("t0_grant_1_cycles", t0_g1, 301);
    chk("t0_grant_2_cycles", t0_g2, 0);
    chk("t0_preempts", t0_pre, 0);

    // Reset while master 2 owns the bus, then master 1 wins the first tie.
    found = 0;
    for (int k = 0; k < 50 && found == 0; k++) begin
      if (g2[2]) found = 1; else cycle();
    end
    chk("find_grant_2", int'(g2[2]), 1);
    do_reset();
    cycle();
    for (int i = 0; i < N; i++) chk($sformatf("post_rst_grant_1[%0d]", i), int'(g1[i]), 1);

    // Random request streams with some persistence.
    for (int k = 0; k < 10000; k++) begin
      if ($urandom_range(5) == 0) req1 = ~req1;
      if ($urandom_range(5) == 0) req2 = ~req2;
      if ($urandom_range(99) == 0) begin
        req1 = 1'b1; req2 = 1'b1;
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
